perf_stats: RTL and testbench

- Parametrised performance-counter block, successor to the single-cycle statistics monitor. It sits beside the CPU core.
- Counts clock cycles, retired instructions and NUM_EVENTS generic event channels (branches, loads, stalls, ...).
- Snapshots all counts into shadow registers and exposes them through a registered read port.
- Computes fixed-point IPC with a multi-cycle restoring divider, so the result is exact instead of integer-truncated.

---
 rtl/perf_stats_if.sv | 32 +++
 rtl/perf_stats.sv | 152 +++++++++++++++
 tb/tb_perf_stats.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_stats_if.sv
// Performance-counter control/read bundle between a core-side driver and perf_stats.
// Carries no clock; every signal is sampled on the perf_stats clk.
interface perf_stats_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_EVENTS = 4
);
    localparam int SELW = $clog2(NUM_EVENTS + 2);

    logic                    countEn;
    logic                    clear;
    logic                    instRetired;
    logic [NUM_EVENTS-1:0]   eventIn;
    logic                    snapshot;
    logic [SELW-1:0]         rdSel;
    logic [WIDTH-1:0]        rdData;
    logic [NUM_EVENTS+1:0]   ovfFlags;
    logic                    ipcStart;
    logic                    ipcBusy;
    logic                    ipcDone;
    logic [WIDTH-1:0]        ipcValue;
    logic                    ipcDivZero;

    modport master (
        output countEn, clear, instRetired, eventIn, snapshot, rdSel, ipcStart,
        input  rdData, ovfFlags, ipcBusy, ipcDone, ipcValue, ipcDivZero
    );

    modport slave (
        input  countEn, clear, instRetired, eventIn, snapshot, rdSel, ipcStart,
        output rdData, ovfFlags, ipcBusy, ipcDone, ipcValue, ipcDivZero
    );
endinterface

// File: rtl/perf_stats.sv
// Cycle/instruction/event counters with shadow snapshot, registered read and exact fixed-point IPC.
// Latency: read 1 cycle, IPC WIDTH+FRAC_BITS cycles (1 on zero cycles); no backpressure, ipcStart ignored while busy.
module perf_stats #(
    parameter int WIDTH      = 32,
    parameter int NUM_EVENTS = 4,
    parameter int FRAC_BITS  = 8,
    parameter int SATURATE   = 1
) (
    input  logic         clk,
    input  logic         reset,
    perf_stats_if.slave  bus
);
    localparam int NCNT = NUM_EVENTS + 2;
    localparam int SELW = $clog2(NUM_EVENTS + 2);
    localparam int DW   = WIDTH + FRAC_BITS;
    localparam int CW   = $clog2(DW + 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

    logic [WIDTH-1:0] liveCnt   [NCNT];
    logic [WIDTH-1:0] shadowCnt [NCNT];
    logic [NCNT-1:0]  ovf;
    logic [NCNT-1:0]  incVec;
    logic [WIDTH-1:0] rdMux;
    logic [WIDTH-1:0] rdData;

    state_t           state;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [DW-1:0]    dq;
    logic [CW-1:0]    iter;
    logic             ipcBusy;
    logic             ipcDone;
    logic             ipcDivZero;
    logic [WIDTH-1:0] ipcValue;

    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remSub;
    logic             qBit;
    logic [WIDTH-1:0] remNext;
    logic [DW-1:0]    qNext;

    // Bit 0 is the cycle counter, which counts every enabled clock.
    assign incVec = {bus.eventIn, bus.instRetired, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) liveCnt[i] <= '0;
            ovf <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < NCNT; i++) liveCnt[i] <= '0;
            ovf <= '0;
        end else if (bus.countEn) begin
            for (int i = 0; i < NCNT; i++) begin
                if (incVec[i]) begin
                    if (liveCnt[i] == ALL_ONES) begin
                        ovf[i]     <= 1'b1;
                        liveCnt[i] <= (SATURATE != 0) ? ALL_ONES : '0;
                    end else begin
                        liveCnt[i] <= liveCnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // Shadows sample the pre-edge live values, so snapshot+clear keeps the old counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) shadowCnt[i] <= '0;
        end else if (bus.snapshot) begin
            for (int i = 0; i < NCNT; i++) shadowCnt[i] <= liveCnt[i];
        end
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (bus.rdSel == SELW'(i)) rdMux = shadowCnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rdData <= '0;
        else       rdData <= rdMux;
    end

    // One restoring step; the borrow out of remSub decides the quotient bit.
    always_comb begin
        remShift = {rem, dq[DW-1]};
        remSub   = remShift - {1'b0, divisor};
        qBit     = ~remSub[WIDTH];
        remNext  = qBit ? remSub[WIDTH-1:0] : remShift[WIDTH-1:0];
        qNext    = {dq[DW-2:0], qBit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            divisor    <= '0;
            rem        <= '0;
            dq         <= '0;
            iter       <= '0;
            ipcBusy    <= 1'b0;
            ipcDone    <= 1'b0;
            ipcDivZero <= 1'b0;
            ipcValue   <= '0;
        end else begin
            ipcDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ipcStart) begin
                        divisor <= shadowCnt[0];
                        dq      <= DW'(shadowCnt[1]) << FRAC_BITS;
                        rem     <= '0;
                        iter    <= '0;
                        ipcBusy <= 1'b1;
                        state   <= (shadowCnt[0] == '0) ? FINISH : DIV;
                    end
                end
                DIV: begin
                    rem  <= remNext;
                    dq   <= qNext;
                    iter <= iter + CW'(1);
                    if (iter == CW'(DW - 1)) begin
                        ipcValue   <= (qNext > DW'(ALL_ONES)) ? ALL_ONES : qNext[WIDTH-1:0];
                        ipcDivZero <= 1'b0;
                        ipcDone    <= 1'b1;
                        ipcBusy    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FINISH: begin
                    ipcValue   <= ALL_ONES;
                    ipcDivZero <= 1'b1;
                    ipcDone    <= 1'b1;
                    ipcBusy    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdData     = rdData;
    assign bus.ovfFlags   = ovf;
    assign bus.ipcBusy    = ipcBusy;
    assign bus.ipcDone    = ipcDone;
    assign bus.ipcValue   = ipcValue;
    assign bus.ipcDivZero = ipcDivZero;
endmodule

// File: tb/tb_perf_stats.sv
// Directed bench for perf_stats: default 32-bit instance plus 8-bit saturating and wrapping instances.
// Stimulus pushes expected reads/IPC results into queues; a negedge monitor pops and compares.
module tb_perf_stats;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       countEn = 1'b0;
    logic       clear = 1'b0;
    logic       instRetired = 1'b0;
    logic [3:0] eventIn = '0;
    logic       snapshot = 1'b0;
    logic [2:0] rdSel = '0;
    logic       ipcStart = 1'b0;

    int nChecks = 0;
    int nFail   = 0;
    int doneCnt = 0;

    logic        rdReq0 = 1'b0, rdVld0 = 1'b0;
    logic        rdReq8 = 1'b0, rdVld8 = 1'b0;
    logic [31:0] rdQ0[$];
    logic [7:0]  rdQ8s[$];
    logic [7:0]  rdQ8w[$];
    logic [32:0] ipcQ[$];

    always #5 clk = ~clk;

    perf_stats_if #(.WIDTH(32), .NUM_EVENTS(4)) bus32 ();
    perf_stats_if #(.WIDTH(8),  .NUM_EVENTS(4)) bus8s ();
    perf_stats_if #(.WIDTH(8),  .NUM_EVENTS(4)) bus8w ();

    perf_stats #(.WIDTH(32), .NUM_EVENTS(4), .FRAC_BITS(8), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus32));
    perf_stats #(.WIDTH(8), .NUM_EVENTS(4), .FRAC_BITS(8), .SATURATE(1)) dut8s (
        .clk(clk), .reset(reset), .bus(bus8s));
    perf_stats #(.WIDTH(8), .NUM_EVENTS(4), .FRAC_BITS(8), .SATURATE(0)) dut8w (
        .clk(clk), .reset(reset), .bus(bus8w));

    assign {bus32.countEn, bus8s.countEn, bus8w.countEn}             = {3{countEn}};
    assign {bus32.clear, bus8s.clear, bus8w.clear}                   = {3{clear}};
    assign {bus32.instRetired, bus8s.instRetired, bus8w.instRetired} = {3{instRetired}};
    assign {bus32.snapshot, bus8s.snapshot, bus8w.snapshot}          = {3{snapshot}};
    assign {bus32.ipcStart, bus8s.ipcStart, bus8w.ipcStart}          = {3{ipcStart}};
    assign bus32.eventIn = eventIn;
    assign bus8s.eventIn = eventIn;
    assign bus8w.eventIn = eventIn;
    assign bus32.rdSel   = rdSel;
    assign bus8s.rdSel   = rdSel;
    assign bus8w.rdSel   = rdSel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic noteFail(input string nm);
        nChecks++;
        nFail++;
        $display("FAIL %s: output presented with no expectation queued", nm);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readMain(input logic [2:0] sel, input logic [31:0] exp);
        rdQ0.push_back(exp);
        rdSel  = sel;
        rdReq0 = 1'b1;
        step();
        rdReq0 = 1'b0;
    endtask

    task automatic read8(input logic [2:0] sel, input logic [7:0] expSat, input logic [7:0] expWrap);
        rdQ8s.push_back(expSat);
        rdQ8w.push_back(expWrap);
        rdSel  = sel;
        rdReq8 = 1'b1;
        step();
        rdReq8 = 1'b0;
    endtask

    task automatic doSnapshot();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic runIpc(input logic [31:0] expVal, input logic expDz, input int expBusy, input bit midStart);
        int  busyCnt;
        int  doneBefore;
        bit  seen;
        busyCnt    = 0;
        seen       = 1'b0;
        doneBefore = doneCnt;
        ipcQ.push_back({expDz, expVal});
        ipcStart = 1'b1;
        step();
        ipcStart = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus32.ipcBusy) busyCnt++;
            if (bus32.ipcDone) seen = 1'b1;
            ipcStart = midStart && (c == 5);
        end
        ipcStart = 1'b0;
        if (!seen) begin
            nChecks++;
            nFail++;
            $display("FAIL ipc_timeout: no ipcDone within 200 cycles, expected one");
        end
        step(3);
        chk("ipc_busy_cycles", 64'(busyCnt), 64'(expBusy));
        chk("ipc_done_pulses", 64'(doneCnt - doneBefore), 64'd1);
        chk("ipc_queue_drained", 64'(ipcQ.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        rdVld0 <= rdReq0;
        rdVld8 <= rdReq8;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] r;
        logic [7:0]  rs, rw;
        if (rdVld0) begin
            if (rdQ0.size() == 0) noteFail("rd_main");
            else begin
                r = rdQ0.pop_front();
                chk("rd_main", 64'(bus32.rdData), 64'(r));
            end
        end
        if (rdVld8) begin
            if (rdQ8s.size() == 0 || rdQ8w.size() == 0) noteFail("rd_w8");
            else begin
                rs = rdQ8s.pop_front();
                rw = rdQ8w.pop_front();
                chk("rd_w8_sat", 64'(bus8s.rdData), 64'(rs));
                chk("rd_w8_wrap", 64'(bus8w.rdData), 64'(rw));
            end
        end
        if (bus32.ipcDone) begin
            doneCnt++;
            if (ipcQ.size() == 0) noteFail("ipc_done");
            else begin
                e = ipcQ.pop_front();
                chk("ipc_result", {31'd0, bus32.ipcDivZero, bus32.ipcValue}, 64'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int doneBefore;
        // Reset state
        step(2);
        chk("rst_rdData", 64'(bus32.rdData), 64'd0);
        chk("rst_ovf", 64'(bus32.ovfFlags), 64'd0);
        chk("rst_ipcValue", 64'(bus32.ipcValue), 64'd0);
        chk("rst_ipcBusy", 64'(bus32.ipcBusy), 64'd0);
        chk("rst_ipcDone", 64'(bus32.ipcDone), 64'd0);
        chk("rst_ipcDivZero", 64'(bus32.ipcDivZero), 64'd0);
        reset = 1'b0;

        // 10 cycles, one instruction each: IPC 1.0
        countEn = 1'b1;
        instRetired = 1'b1;
        step(10);
        countEn = 1'b0;
        instRetired = 1'b0;
        doSnapshot();
        readMain(3'd0, 32'd10);
        readMain(3'd1, 32'd10);
        runIpc(32'h100, 1'b0, 40, 1'b0);

        // 20 cycles, 5 instructions: IPC 0.25, with an ignored mid-busy start
        clear = 1'b1;
        step();
        clear = 1'b0;
        countEn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instRetired = (i % 4 == 0);
            step();
        end
        countEn = 1'b0;
        instRetired = 1'b0;
        doSnapshot();
        readMain(3'd0, 32'd20);
        readMain(3'd1, 32'd5);
        runIpc(32'h40, 1'b0, 40, 1'b1);

        // 300 events on 8-bit counters: saturate at 255, wrap to 44
        pulseReset();
        countEn = 1'b1;
        eventIn = 4'b0001;
        step(300);
        countEn = 1'b0;
        eventIn = '0;
        doSnapshot();
        read8(3'd2, 8'd255, 8'd44);
        read8(3'd0, 8'd255, 8'd44);
        read8(3'd1, 8'd0, 8'd0);
        chk("ovf_w8_sat", 64'(bus8s.ovfFlags), 64'b000101);
        chk("ovf_w8_wrap", 64'(bus8w.ovfFlags), 64'b000101);
        chk("ovf_w32_none", 64'(bus32.ovfFlags), 64'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovf_w8_sat_clr", 64'(bus8s.ovfFlags), 64'd0);
        chk("ovf_w8_wrap_clr", 64'(bus8w.ovfFlags), 64'd0);

        // Zero cycles: divide-by-zero result in one cycle
        pulseReset();
        doSnapshot();
        runIpc(32'hFFFF_FFFF, 1'b1, 1, 1'b0);

        // Simultaneous clear+snapshot, restart, frozen counting
        pulseReset();
        countEn = 1'b1;
        step(7);
        clear = 1'b1;
        snapshot = 1'b1;
        step();
        clear = 1'b0;
        snapshot = 1'b0;
        readMain(3'd0, 32'd7);
        step(2);
        countEn = 1'b0;
        doSnapshot();
        readMain(3'd0, 32'd3);
        step(5);
        doSnapshot();
        readMain(3'd0, 32'd3);
        readMain(3'd1, 32'd0);

        // Out-of-range reads, then reset mid-division
        pulseReset();
        countEn = 1'b1;
        instRetired = 1'b1;
        eventIn = 4'b1111;
        step(10);
        countEn = 1'b0;
        instRetired = 1'b0;
        eventIn = '0;
        doSnapshot();
        readMain(3'd5, 32'd10);
        readMain(3'd7, 32'd0);
        readMain(3'd6, 32'd0);
        doneBefore = doneCnt;
        ipcStart = 1'b1;
        step();
        ipcStart = 1'b0;
        step(14);
        chk("div_busy_mid", 64'(bus32.ipcBusy), 64'd1);
        reset = 1'b1;
        step();
        chk("abort_busy", 64'(bus32.ipcBusy), 64'd0);
        chk("abort_done", 64'(bus32.ipcDone), 64'd0);
        chk("abort_value", 64'(bus32.ipcValue), 64'd0);
        reset = 1'b0;
        step(60);
        chk("abort_no_done", 64'(doneCnt - doneBefore), 64'd0);
        readMain(3'd0, 32'd0);

        step(3);
        chk("rdq_main_drained", 64'(rdQ0.size()), 64'd0);
        chk("rdq_w8_drained", 64'(rdQ8s.size() + rdQ8w.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule
